// File: rtl/jpeg_pkg.sv
// ---------------------------------------------------------------------------
// jpeg_pkg
// Shared types for the JPEG framebuffer writer:
//   ADDR_W / DATA_W : memory write bus widths (32 bits each)
//   fb_state_e      : frame-tracking FSM states
//   pixel_t         : one decoded pixel (coordinate + colour)
//   wr_req_t        : one queued memory write (address + data)
// ---------------------------------------------------------------------------
package jpeg_pkg;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int COORD_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_DONE
  } fb_state_e;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [7:0]         r;
    logic [7:0]         g;
    logic [7:0]         b;
  } pixel_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/jpeg_fb_fifo.sv
// ---------------------------------------------------------------------------
// jpeg_fb_fifo
// Synchronous FIFO holding pending framebuffer writes. Push and pop may occur
// in the same cycle (also when full); full/empty/count are registered.
// Ports:
//   clk_i, rst_i      : clock, synchronous active-high reset
//   push_i, data_i    : write side
//   pop_i, data_o     : read side (data_o shows the head entry)
//   full_o, empty_o   : registered status flags
//   count_o           : registered occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module jpeg_fb_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, empty_q;
  logic             do_push, do_pop;

  assign do_pop  = pop_i && !empty_q;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_push = push_i && (!full_q || do_pop);

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
      full_q  <= (count_d == CNT_W'(DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers and
  // count define which entries are meaningful, so the contents never leak.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign count_o = count_q;

endmodule

// File: rtl/jpeg_fb_writer.sv
// ---------------------------------------------------------------------------
// jpeg_fb_writer
// Turns decoded pixels into 32-bit framebuffer writes ({8'h00,r,g,b} at
// BASE_ADDR + 4*(y*width + x)), queues them, and tracks frame completion.
// Ports:
//   clk_i, rst_i                      : clock, synchronous active-high reset
//   pixel_valid_i / pixel_accept_o    : pixel handshake from decoder core
//   width_i, height_i                 : frame dimensions
//   pixel_x_i, pixel_y_i, pixel_[rgb]_i : pixel coordinate and colour
//   wr_valid_o / wr_ready_i           : memory write handshake
//   wr_addr_o, wr_data_o              : memory write address/data
//   frame_done_o                      : one-cycle pulse at frame completion
//   err_oob_o                         : sticky out-of-bounds-drop flag
//   busy_o                            : frame in progress or data in flight
// ---------------------------------------------------------------------------
module jpeg_fb_writer
  import jpeg_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR  = 32'h0000_0000,
  parameter int                FIFO_DEPTH = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               pixel_valid_i,
  output logic               pixel_accept_o,
  input  logic [COORD_W-1:0] width_i,
  input  logic [COORD_W-1:0] height_i,
  input  logic [COORD_W-1:0] pixel_x_i,
  input  logic [COORD_W-1:0] pixel_y_i,
  input  logic [7:0]         pixel_r_i,
  input  logic [7:0]         pixel_g_i,
  input  logic [7:0]         pixel_b_i,
  output logic               wr_valid_o,
  input  logic               wr_ready_i,
  output logic [ADDR_W-1:0]  wr_addr_o,
  output logic [DATA_W-1:0]  wr_data_o,
  output logic               frame_done_o,
  output logic               err_oob_o,
  output logic               busy_o
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  // Stage S1: one registered pixel plus its bounds verdict.
  logic      s1_valid_q, s1_valid_d;
  logic      s1_inb_q,   s1_inb_d;
  pixel_t    s1_pix_q,   s1_pix_d;

  logic             in_bounds, accept, push, wr_fire;
  logic [31:0]      offset;
  wr_req_t          push_req, head_req;
  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;

  fb_state_e   state_q, state_d;
  logic [31:0] total_q, total_d;
  logic [31:0] wr_cnt_q, wr_cnt_d;
  logic        err_oob_q, err_oob_d;

  // Acceptance looks only at registered occupancy (queue + S1), so a pixel
  // taken now always has a slot even if memory stalls forever.
  assign in_bounds      = (pixel_x_i < width_i) && (pixel_y_i < height_i);
  assign pixel_accept_o = !rst_i && !fifo_full &&
                          ((int'(fifo_count) + int'(s1_valid_q)) < FIFO_DEPTH);
  assign accept         = pixel_valid_i && pixel_accept_o;

  always_comb begin
    s1_valid_d = accept;
    s1_inb_d   = s1_inb_q;
    s1_pix_d   = s1_pix_q;
    if (accept) begin
      s1_inb_d = in_bounds;
      s1_pix_d = '{x: pixel_x_i, y: pixel_y_i,
                   r: pixel_r_i, g: pixel_g_i, b: pixel_b_i};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid_q <= 1'b0;
      s1_inb_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_inb_q   <= s1_inb_d;
    end
    s1_pix_q <= s1_pix_d;
  end

  // Address arithmetic wraps modulo 2^32 by construction.
  assign offset        = 32'(s1_pix_q.y) * 32'(width_i) + 32'(s1_pix_q.x);
  assign push_req.addr = BASE_ADDR + (offset << 2);
  assign push_req.data = {8'h00, s1_pix_q.r, s1_pix_q.g, s1_pix_q.b};
  assign push          = s1_valid_q && s1_inb_q;

  jpeg_fb_fifo #(
    .WIDTH ($bits(wr_req_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .data_i  (push_req),
    .pop_i   (wr_fire),
    .data_o  (head_req),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign wr_fire    = !fifo_empty && wr_ready_i;
  assign wr_valid_o = !fifo_empty;
  assign wr_addr_o  = head_req.addr;
  assign wr_data_o  = head_req.data;

  // Frame FSM: state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Frame FSM: next state. Writes outside ACTIVE are issued but not counted.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (accept && in_bounds) state_d = ST_ACTIVE;
      ST_ACTIVE: if (wr_fire && (wr_cnt_q + 32'd1 == total_q)) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Frame FSM: outputs.
  always_comb begin
    frame_done_o = (state_q == ST_DONE);
    busy_o       = (state_q != ST_IDLE) || s1_valid_q || !fifo_empty;
  end

  // Frame bookkeeping: total latched at frame start, writes counted in ACTIVE.
  always_comb begin
    total_d   = total_q;
    wr_cnt_d  = wr_cnt_q;
    err_oob_d = err_oob_q || (s1_valid_q && !s1_inb_q);
    if (state_q == ST_IDLE && accept && in_bounds) begin
      total_d  = 32'(width_i) * 32'(height_i);
      wr_cnt_d = '0;
    end else if (state_q == ST_ACTIVE && wr_fire) begin
      wr_cnt_d = wr_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      total_q   <= '0;
      wr_cnt_q  <= '0;
      err_oob_q <= 1'b0;
    end else begin
      total_q   <= total_d;
      wr_cnt_q  <= wr_cnt_d;
      err_oob_q <= err_oob_d;
    end
  end

  assign err_oob_o = err_oob_q;

endmodule

// File: tb/tb_jpeg_fb_writer.sv
// ---------------------------------------------------------------------------
// tb_jpeg_fb_writer
// Directed bench for jpeg_fb_writer: a raster table of a 4x2 frame at base
// 0x1000 with hand-computed addresses/data, plus sequences for back-pressure,
// out-of-bounds drop, mid-frame reset and back-to-back 1x1 frames.
// ---------------------------------------------------------------------------
module tb_jpeg_fb_writer;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        pixel_valid_i, pixel_accept_o;
  logic [15:0] width_i, height_i, pixel_x_i, pixel_y_i;
  logic [7:0]  pixel_r_i, pixel_g_i, pixel_b_i;
  logic        wr_valid_o, wr_ready_i;
  logic [31:0] wr_addr_o, wr_data_o;
  logic        frame_done_o, err_oob_o, busy_o;

  jpeg_fb_writer #(
    .BASE_ADDR  (BASE),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .pixel_valid_i  (pixel_valid_i),
    .pixel_accept_o (pixel_accept_o),
    .width_i        (width_i),
    .height_i       (height_i),
    .pixel_x_i      (pixel_x_i),
    .pixel_y_i      (pixel_y_i),
    .pixel_r_i      (pixel_r_i),
    .pixel_g_i      (pixel_g_i),
    .pixel_b_i      (pixel_b_i),
    .wr_valid_o     (wr_valid_o),
    .wr_ready_i     (wr_ready_i),
    .wr_addr_o      (wr_addr_o),
    .wr_data_o      (wr_data_o),
    .frame_done_o   (frame_done_o),
    .err_oob_o      (err_oob_o),
    .busy_o         (busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
    logic [31:0] addr;
    logic [31:0] data;
    logic        done;
  } vec_t;

  vec_t tbl [8];
  vec_t v_oob, v_one_a, v_one_b;

  int checks   = 0;
  int passed   = 0;
  int done_cnt = 0;
  int k, acc, unstable, n, cnt, d0;
  logic a;

  always @(posedge clk) if (frame_done_o === 1'b1) done_cnt <= done_cnt + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic set_pix(input vec_t v);
    pixel_x_i = v.x;
    pixel_y_i = v.y;
    pixel_r_i = v.r;
    pixel_g_i = v.g;
    pixel_b_i = v.b;
  endtask

  // Presents one pixel until accepted; returns just after the accepting edge.
  task automatic send_pixel(input vec_t v);
    int w = 0;
    @(posedge clk); #1;
    set_pix(v);
    pixel_valid_i = 1'b1;
    @(negedge clk);
    while (!pixel_accept_o && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("accept_wait", 32'(w < 50), 32'd1);
    @(posedge clk); #1;
    pixel_valid_i = 1'b0;
  endtask

  // Waits for the write (cycles counted from acceptance), checks it, then
  // checks frame_done_o in the cycle after the handshake.
  task automatic expect_write(input string name, input logic [31:0] ea,
                              input logic [31:0] ed, input int elat, input logic edone);
    int lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!wr_valid_o && lat < 50);
    check({name, "_valid"}, 32'(wr_valid_o), 32'd1);
    check({name, "_latency"}, lat, elat);
    check({name, "_addr"}, wr_addr_o, ea);
    check({name, "_data"}, wr_data_o, ed);
    @(negedge clk);
    check({name, "_done"}, 32'(frame_done_o), 32'(edone));
  endtask

  task automatic run_table(input string tag);
    int start = done_cnt;
    for (int i = 0; i < 8; i++) begin
      send_pixel(tbl[i]);
      expect_write($sformatf("%s[%0d]", tag, i), tbl[i].addr, tbl[i].data, 2, tbl[i].done);
    end
    @(negedge clk);
    check({tag, "_pulses"}, done_cnt - start, 1);
    check({tag, "_idle_busy"}, 32'(busy_o), 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_i = 1'b1;
    pixel_valid_i = 1'b0;
    @(negedge clk);
    check("rst_accept_low", 32'(pixel_accept_o), 32'd0);
    @(posedge clk); #1;
    rst_i = 1'b0;
    @(negedge clk);
    check("rst_accept_after", 32'(pixel_accept_o), 32'd1);
    check("rst_wr_valid", 32'(wr_valid_o), 32'd0);
    check("rst_frame_done", 32'(frame_done_o), 32'd0);
    check("rst_err_oob", 32'(err_oob_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
  endtask

  initial begin
    // x, y, r, g, b, addr = 0x1000 + 4*(y*4+x), data = {00,r,g,b}, done
    tbl[0] = '{16'd0, 16'd0, 8'h11, 8'h22, 8'h33, 32'h0000_1000, 32'h0011_2233, 1'b0};
    tbl[1] = '{16'd1, 16'd0, 8'h44, 8'h55, 8'h66, 32'h0000_1004, 32'h0044_5566, 1'b0};
    tbl[2] = '{16'd2, 16'd0, 8'h77, 8'h88, 8'h99, 32'h0000_1008, 32'h0077_8899, 1'b0};
    tbl[3] = '{16'd3, 16'd0, 8'hAA, 8'hBB, 8'hCC, 32'h0000_100C, 32'h00AA_BBCC, 1'b0};
    tbl[4] = '{16'd0, 16'd1, 8'h01, 8'h02, 8'h03, 32'h0000_1010, 32'h0001_0203, 1'b0};
    tbl[5] = '{16'd1, 16'd1, 8'hFF, 8'h00, 8'hFF, 32'h0000_1014, 32'h00FF_00FF, 1'b0};
    tbl[6] = '{16'd2, 16'd1, 8'h80, 8'h40, 8'h20, 32'h0000_1018, 32'h0080_4020, 1'b0};
    tbl[7] = '{16'd3, 16'd1, 8'h12, 8'h34, 8'h56, 32'h0000_101C, 32'h0012_3456, 1'b1};
    v_oob   = '{16'd4, 16'd0, 8'hDE, 8'hAD, 8'hBE, 32'h0, 32'h0, 1'b0};
    v_one_a = '{16'd0, 16'd0, 8'hA1, 8'hB2, 8'hC3, 32'h0000_1000, 32'h00A1_B2C3, 1'b1};
    v_one_b = '{16'd0, 16'd0, 8'h0F, 8'h1E, 8'h2D, 32'h0000_1000, 32'h000F_1E2D, 1'b1};

    pixel_valid_i = 1'b0;
    wr_ready_i    = 1'b1;
    width_i       = 16'd4;
    height_i      = 16'd2;
    set_pix(tbl[0]);

    // Raster 4x2 frame with memory always ready.
    do_reset();
    run_table("raster");

    // Back-pressure: memory stalled, input offered every cycle.
    do_reset();
    wr_ready_i = 1'b0;
    @(posedge clk); #1;
    set_pix(tbl[0]);
    pixel_valid_i = 1'b1;
    k = 0; acc = 0; unstable = 0;
    repeat (10) begin
      @(negedge clk);
      a = pixel_accept_o;
      if (wr_valid_o && (wr_addr_o !== tbl[0].addr || wr_data_o !== tbl[0].data)) unstable++;
      @(posedge clk); #1;
      if (a) begin
        acc++;
        k++;
        if (k < 8) set_pix(tbl[k]);
      end
    end
    @(negedge clk);
    check("stall_accepted", acc, DEPTH);
    check("stall_accept_low", 32'(pixel_accept_o), 32'd0);
    check("stall_wr_valid", 32'(wr_valid_o), 32'd1);
    check("stall_unstable", unstable, 0);
    check("stall_head_data", wr_data_o, tbl[0].data);
    @(posedge clk); #1;
    pixel_valid_i = 1'b0;
    wr_ready_i    = 1'b1;
    for (int j = 0; j < DEPTH; j++) begin
      n = 0;
      @(negedge clk);
      while (!wr_valid_o && n < 20) begin
        @(negedge clk);
        n++;
      end
      check($sformatf("drain[%0d]_addr", j), wr_addr_o, tbl[j].addr);
      check($sformatf("drain[%0d]_data", j), wr_data_o, tbl[j].data);
    end
    @(negedge clk);
    check("drain_empty", 32'(wr_valid_o), 32'd0);

    // Out-of-bounds pixel dropped, flag sticky, frame still completes.
    do_reset();
    send_pixel(v_oob);
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (wr_valid_o) cnt++;
    end
    check("oob_no_write", cnt, 0);
    check("oob_flag", 32'(err_oob_o), 32'd1);
    run_table("oob_frame");
    check("oob_flag_sticky", 32'(err_oob_o), 32'd1);

    // Reset after 3 of 8 pixels with writes stalled.
    do_reset();
    wr_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) send_pixel(tbl[i]);
    repeat (2) @(negedge clk);
    check("mid_busy", 32'(busy_o), 32'd1);
    check("mid_wr_valid", 32'(wr_valid_o), 32'd1);
    d0 = done_cnt;
    do_reset();
    wr_ready_i = 1'b1;
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (wr_valid_o) cnt++;
    end
    check("mid_no_write", cnt, 0);
    check("mid_no_done", done_cnt - d0, 0);

    // Two back-to-back 1x1 frames.
    width_i  = 16'd1;
    height_i = 16'd1;
    d0 = done_cnt;
    send_pixel(v_one_a);
    expect_write("one_a", v_one_a.addr, v_one_a.data, 2, v_one_a.done);
    send_pixel(v_one_b);
    expect_write("one_b", v_one_b.addr, v_one_b.data, 2, v_one_b.done);
    @(negedge clk);
    check("one_pulses", done_cnt - d0, 2);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/jpeg_fb_writer.md
JPEG_FB_WRITER -- requirements
Module: jpeg_fb_writer

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0000: byte address of framebuffer pixel (0,0).
REQ-002 Parameter FIFO_DEPTH, default 4: write-queue entries; power of two, at least 2.
REQ-003 clk_i  in  1  single clock; all logic on rising edge.
REQ-004 rst_i  in  1  reset, synchronous, active-high.
REQ-005 pixel_valid_i  in  1  pixel beat valid from decoder core.
REQ-006 pixel_accept_o  out  1  pixel beat consumed this cycle when high with pixel_valid_i.
REQ-007 width_i, height_i  in  16 each  image dimensions, stable for a whole frame.
REQ-008 pixel_x_i, pixel_y_i  in  16 each  pixel coordinate.
REQ-009 pixel_r_i, pixel_g_i, pixel_b_i  in  8 each  colour components.
REQ-010 wr_valid_o  out  1  memory write request valid.
REQ-011 wr_ready_i  in  1  memory accepts request when high with wr_valid_o.
REQ-012 wr_addr_o  out  32  byte address; wr_data_o  out  32  {8'h00,r,g,b}.
REQ-013 frame_done_o  out  1  one-cycle pulse when the last pixel of a frame is written.
REQ-014 err_oob_o  out  1  sticky flag: out-of-bounds pixel dropped.
REQ-015 busy_o  out  1  high while in ACTIVE/DONE or any entry in flight.

Function
REQ-016 Pipeline: accepted pixel registered in stage S1 (valid bit, coordinates, colour); S1 computes offset = y*width + x (32-bit, unsigned), addr = BASE_ADDR + (offset << 2), modulo 2^32.
REQ-017 S1 pushes into FIFO next cycle; earliest wr_valid_o is 2 cycles after acceptance.
REQ-018 pixel_accept_o = (FIFO occupancy + S1 valid) < FIFO_DEPTH, from registered state only; no combinational path from wr_ready_i.
REQ-019 FIFO simultaneous push and pop permitted in one cycle, occupancy unchanged; pop occurs when wr_valid_o && wr_ready_i.
REQ-020 wr_valid_o = FIFO non-empty; wr_addr_o/wr_data_o held stable while wr_valid_o high and wr_ready_i low.
REQ-021 Write order equals pixel acceptance order.
REQ-022 Pixel with x >= width or y >= height (includes width or height 0) is accepted, not pushed, not counted; err_oob_o set, stays set until reset.
REQ-023 FSM states IDLE, ACTIVE, DONE.
REQ-024 IDLE -> ACTIVE on first in-bounds accepted pixel; latch total = width*height (32-bit), clear write counter.
REQ-025 ACTIVE: write counter increments per write handshake; on handshake making counter == total -> DONE.
REQ-026 DONE: frame_done_o = 1 for exactly that cycle; -> IDLE next cycle; pixel acceptance continues in all states.
REQ-027 Single-pixel frame (1x1): IDLE -> ACTIVE -> DONE with one write, one pulse.
REQ-028 Writes beyond total within a frame are still issued; they count toward the next frame only after IDLE re-entry.

Reset
REQ-029 On rst_i: S1 and FIFO empty, FSM IDLE, counters 0, pixel_accept_o 0 during reset, wr_valid_o 0, frame_done_o 0, err_oob_o 0, busy_o 0.
REQ-030 Reset mid-frame discards in-flight pixels; no write, no frame_done_o afterwards for that frame.
REQ-031 pixel_accept_o high first cycle after rst_i deasserts.

Structure
REQ-032 Shared package jpeg_pkg holds FSM state enum, pixel record typedef (x, y, r, g, b), and 32-bit address/data width constants.
REQ-033 FIFO is sub-module jpeg_fb_fifo (parameterised width/depth, registered full/empty/count).

Verification
REQ-034 4x2 frame, BASE 0x1000, wr_ready_i=1, raster order -> 8 writes, addresses 0x1000..0x101C step 4, frame_done_o one pulse on 8th write.
REQ-035 Pixel (3,1) width 4, RGB 0x12,0x34,0x56 -> wr_addr 0x1000+0x1C, wr_data 0x00123456, two cycles after accept.
REQ-036 wr_ready_i=0 for 10 cycles with continuous input -> exactly FIFO_DEPTH pixels accepted, then pixel_accept_o 0; data stable; release drains in order.
REQ-037 Pixel x=4 in width 4 -> no write, err_oob_o 1 and sticky; frame still completes after 8 valid pixels.
REQ-038 rst_i asserted after 3 of 8 pixels with writes stalled -> all outputs reset values next cycle, no frame_done_o.
REQ-039 1x1 frame followed immediately by second 1x1 frame -> two writes, two distinct frame_done_o pulses.
